dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data-memory port (9-bit word address, DATA_W data) between the core load/store path and a debug/loader requester.
- Core has default priority.
- A starvation counter guarantees debug forward progress.
- While the core is Halted, debug gets strict priority.
- Sits between Datapath memory signals and the data memory. Drives the memory wr/rd/addr/wr_data and returns read data with a 1-cycle registered latency.

Parameters:
DATA_W, 32, data width of memory words
ADDR_W, 9, memory word-address width
MAX_WAIT, 4, consecutive denied debug-request cycles before debug is force-granted (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
halted  in  1  core Halted status; 1 = debug has strict priority
core_req  in  1  core memory access request
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  core word address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core access accepted this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid (1 cycle after granted read)
dbg_req  in  1  debug memory access request
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug access accepted this cycle
dbg_rvalid  out  1  debug read data valid
rdata  out  DATA_W  registered read data, shared by both requesters
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in the cycle mem_rd is high

Behaviour:
- Grant logic is combinational from the req inputs and registered state. At most one of core_gnt/dbg_gnt is high per cycle.
- Grant priority, highest first:
  - (a) reset=1: no grant.
  - (b) halted=1 and dbg_req: debug.
  - (c) force_dbg=1 and dbg_req: debug.
  - (d) core_req: core.
  - (e) dbg_req: debug.
- Memory drive:
  - Granted requester's addr/wdata muxed to mem_addr/mem_wdata.
  - mem_wr = gnt & we; mem_rd = gnt & ~we.
  - No grant: mem_wr = mem_rd = 0, mem_addr/mem_wdata = 0.
- Starvation counter wait_cnt (4 bits):
  - Increments each cycle with dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or dbg_req=0.
  - force_dbg = (wait_cnt == MAX_WAIT).
  - Forced grant lasts exactly one access, then the counter clears.
- Read return pipeline:
  - Registers rd_pend (1 bit) and rd_owner (0 = core, 1 = debug) on every cycle.
  - Cycle after a granted read: rdata <= mem_rdata, and exactly one of core_rvalid/dbg_rvalid pulses high for one cycle.
  - rdata holds its last value otherwise.
- Back-to-back reads from either requester are fully pipelined, one per cycle. Writes produce no rvalid.
- Simultaneous core write and debug read (or any mix): only the winner's access happens. The loser sees gnt=0, must hold its req/addr/wdata stable, and retries automatically next cycle.
- halted falling mid-burst: priority reverts to core from the next cycle. An in-flight rvalid is still delivered to its owner.
- Reset (sync, any cycle including mid-read):
  - wait_cnt=0, rd_pend=0, rvalid outputs 0, rdata=0, all grants and mem strobes 0.
  - A pending read issued in the reset cycle is dropped.
- Address width is exactly ADDR_W bits; no range checking.

Optional Feature:
Macro: DMEM_ARB_STATS_EN
- Defined:
  - Adds outputs stat_core_stalls (16 bits, counts cycles with core_stall=1) and stat_dbg_grants (16 bits, counts dbg_gnt cycles).
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; arbitration behaviour identical.

Test Plan:
- Core only: core_req=1, we=0, addr=9'h010, mem_rdata=32'hDEADBEEF → core_gnt=1 same cycle, mem_rd=1, mem_addr=9'h010; next cycle core_rvalid=1, rdata=32'hDEADBEEF, dbg_rvalid=0.
- Contention: core_req and dbg_req held high continuously, MAX_WAIT=4 → core granted cycles 0-3, debug granted cycle 4, core granted cycles 5-8, debug granted cycle 9; core_stall=1 exactly on cycles 4 and 9.
- Halted: halted=1, both requesting, dbg_we=1, dbg_addr=9'h1FF, dbg_wdata=32'h12345678 → dbg_gnt=1, mem_wr=1, mem_addr=9'h1FF, mem_wdata=32'h12345678, core_stall=1.
- Pipelined mixed reads: core read addr 1, then debug read addr 2 (halted=1) on consecutive cycles → core_rvalid on cycle 1, dbg_rvalid on cycle 2, each with its mem_rdata; never both high.
- Reset mid-read: granted core read at cycle N, reset=1 at cycle N+1 → core_rvalid=0 at N+1 and N+2, rdata=0, wait_cnt=0, no mem strobes while reset=1.
- With DMEM_ARB_STATS_EN: contention scenario for 10 cycles → stat_core_stalls=2, stat_dbg_grants=2; force counter to 16'hFFFF and continue → holds at 16'hFFFF.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- bundle of every signal between the data-memory arbiter,
// its two requesters (core load/store path, debug/loader) and the memory.
//
// Handshake: a requester raises *_req together with *_we/*_addr/*_wdata and
// keeps all four stable until it sees *_gnt high in the same cycle; that cycle
// is the transfer. A read transfer is answered one cycle later by a single-
// cycle *_rvalid pulse with the word on the shared rdata bus. Writes produce
// no response. The memory side has no back-pressure: mem_wr/mem_rd are
// one-cycle commands and mem_rdata is valid in the cycle mem_rd is high.
//
// Modports:
//   slave  -- arbiter view (requests, halted and mem_rdata in; grants,
//             responses and memory command out)
//   master -- environment view (requesters plus memory)
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              halted;

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  halted,
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid,
    output rdata,
    output mem_wr, mem_rd, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output halted,
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid,
    input  rdata,
    input  mem_wr, mem_rd, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single data-memory port between the core
// load/store path and the debug/loader requester.
//
// Priority (highest first): reset (nothing granted), debug while the core is
// halted, debug when its starvation counter has reached MAX_WAIT, core, debug.
// A forced debug grant covers exactly one access; the counter then clears.
// Read data returns one cycle after the grant on the shared rdata register
// with a one-cycle rvalid pulse to whichever requester owned the read.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   bus            dmem_arbiter_if.slave (requests, grants, responses, memory)
//   arb_wait_cnt   current debug starvation count (observability)
//   stat_core_stalls, stat_dbg_grants
//                  16-bit saturating event counters, present only when the
//                  macro DMEM_ARB_STATS_EN is defined
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus,
  output logic [3:0]   arb_wait_cnt
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]  stat_core_stalls,
  output logic [15:0]  stat_dbg_grants
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              force_dbg;
  logic              core_win;
  logic              dbg_win;
  logic              rd_pend;
  logic              rd_owner;   // 0 = core, 1 = debug
  logic [DATA_W-1:0] rdata_q;

  assign force_dbg = (wait_cnt == MAX_WAIT_C);

  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (!reset) begin
      if (bus.dbg_req && (bus.halted || force_dbg)) begin
        dbg_win = 1'b1;
      end else if (bus.core_req) begin
        core_win = 1'b1;
      end else if (bus.dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  // Only the winner reaches the memory; an idle port drives zeros.
  always_comb begin
    bus.mem_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (core_win) begin
      bus.mem_wr    = bus.core_we;
      bus.mem_rd    = ~bus.core_we;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = bus.core_wdata;
    end else if (dbg_win) begin
      bus.mem_wr    = bus.dbg_we;
      bus.mem_rd    = ~bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  assign bus.core_gnt   = core_win;
  assign bus.dbg_gnt    = dbg_win;
  assign bus.core_stall = bus.core_req & ~core_win;

  // rvalid is masked by reset so a read granted just before reset is
  // never reported, even in the reset cycle itself.
  assign bus.core_rvalid = rd_pend & ~rd_owner & ~reset;
  assign bus.dbg_rvalid  = rd_pend &  rd_owner & ~reset;
  assign bus.rdata       = rdata_q;
  assign arb_wait_cnt    = wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rdata_q  <= {DATA_W{1'b0}};
    end else begin
      // A granted debug access (forced or not) or an idle debug port clears.
      if (bus.dbg_req && !dbg_win) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= 4'd0;
      end
      rd_pend  <= bus.mem_rd;
      rd_owner <= dbg_win;
      if (bus.mem_rd) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_core_stalls <= 16'd0;
      stat_dbg_grants  <= 16'd0;
    end else begin
      if (bus.core_stall && (stat_core_stalls != 16'hFFFF)) begin
        stat_core_stalls <= stat_core_stalls + 16'd1;
      end
      if (dbg_win && (stat_dbg_grants != 16'hFFFF)) begin
        stat_dbg_grants <= stat_dbg_grants + 16'd1;
      end
    end
  end
`endif

endmodule
